instr_encoder_loader: RTL
=========================

# instr_encoder_loader

Sequential instruction encoder and IMEM loader: the inverse of the pipeline's decode-stage control unit. It accepts instruction fields (kind, registers, funct3, alt bit, 12-bit immediate) over a valid/ready handshake and packs them into 32-bit RV-style instruction words. It writes those words into instruction memory at consecutive addresses from a programmable base. It sits between the host/test loader and the IMEM write port. Every word it emits must decode back to the same control bundle and 12-bit immediate in the control unit.

## Interface
- ADDR_W, 9, IMEM word-address width; addresses wrap modulo 2^ADDR_W
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a load run; sampled only in IDLE
- base_addr  in  ADDR_W  first IMEM word address; captured on start
- length  in  ADDR_W+1  number of words to load; captured on start
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept a bundle
- in_kind  in  3  0 LW(ld), 1 SW(sd), 2 OP-IMM, 3 R-type, 4 BEQ, 5 JAL, 6–7 illegal
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3; used only for OP-IMM and R-type
- in_alt  in  1  instruction bit 30 for R-type (SUB/SRA)
- in_imm  in  12  immediate; for BEQ and JAL it is the offset in halfwords
- imem_we  out  1  IMEM write strobe
- imem_addr  out  ADDR_W  IMEM write address
- imem_wdata  out  32  encoded instruction
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at run end
- illegal  out  1  sticky; set on an illegal kind, cleared by the next accepted start
- word_cnt  out  ADDR_W+1  words written in the current or last run

## Operation
- Bits [1:0] of every opcode are 11. Bits [6:2] of the opcode:
  - LW 00000, SW 01000, OP-IMM 00100, R 01100, BEQ 11000, JAL 11011.
- LW: [31:20]=imm, [19:15]=rs1, funct3 forced to 011, [11:7]=rd.
- SW: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, funct3 forced to 011, [11:7]=imm[4:0].
- OP-IMM: [31:20]=imm, rs1, in_funct3, rd.
- R-type: [31:25]={0, in_alt, 00000}, rs2, rs1, in_funct3, rd.
- BEQ: funct3 forced to 000, rs2, rs1.
  - [31]=imm[11], [7]=imm[10], [30:25]=imm[9:4], [11:8]=imm[3:0].
- JAL: [11:7]=rd.
  - [31]=imm[11], [20]=imm[10], [30:21]=imm[9:0].
  - [19:12] all set to imm[11] (sign extension).
- Illegal kind: the word 0x00000013 (NOP) is written and illegal is set.
- Fields not used by a format are ignored. In unused positions the output bits are fixed by the format above, never taken from the input.
- FSM states: IDLE, LOAD, WRITE, DONE.
  - IDLE: on start, capture base_addr and length and clear word_cnt and illegal. If length==0, go to DONE; otherwise go to LOAD.
  - LOAD: in_ready=1. On in_valid&&in_ready, register the encoded word and go to WRITE.
  - WRITE: imem_we=1 for exactly one cycle. Then increment the address (wrapping) and word_cnt. If the new word_cnt equals length, go to DONE; otherwise go to LOAD.
  - DONE: done=1 for one cycle, then go to IDLE.
- start outside IDLE is ignored.
- in_valid outside LOAD is ignored; no bundle is consumed.

## Timing
- Reset values:
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - busy=0, done=0, illegal=0, word_cnt=0.
  - FSM in IDLE.
- Reset mid-run aborts immediately. No further writes occur, and no partial write is issued after rst_n deasserts.
- All outputs are registered or decoded directly from the state. There is no combinational path from in_* to any output.
- start at edge T: busy and in_ready are high from T+1.
- Bundle accepted at edge T: imem_we, imem_addr and imem_wdata are valid during cycle T+1. in_ready is low in that cycle.
- Maximum throughput is one word per 2 cycles.
- After the last write, done pulses in the next cycle. busy drops the cycle after done.
- length==0: done pulses 1 cycle after start, and no write occurs.
- Address wrap: the address after 2^ADDR_W−1 is 0. word_cnt does not wrap, because length ≤ 2^ADDR_W.

## Test plan
- OP-IMM rd=5, rs1=1, funct3=000, imm=0xFFF, base=0, length=1 -> single write to addr 0 with data 0xFFF08293; done one cycle later; word_cnt=1.
- R-type rd=3, rs1=1, rs2=2, funct3=000, alt=1 followed by BEQ rs1=1, rs2=2, imm=0x002 -> writes 0x402081B3 then 0x00208263 to consecutive addresses; in_valid held high throughout gives exactly one write per 2 cycles.
- LW rd=4, rs1=1, imm=0x010 followed by SW rs1=1, rs2=2, imm=0x008 -> writes 0x0100B203 then 0x0020B423.
- Kind 7 in a 3-word run -> that slot holds 0x00000013 and illegal goes high and stays high; the next start clears illegal.
- base=511, length=2 -> writes go to addr 511 then addr 0; a start pulse issued mid-run is ignored.
- rst_n pulled low while in WRITE -> imem_we falls immediately; all outputs return to their reset values; after release, no write occurs without a new start.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs decoded instruction fields back into 32-bit RV-style words and
//   streams them into IMEM at consecutive (wrapping) word addresses starting
//   at a programmable base. Every emitted word decodes to the same control
//   bundle and 12-bit immediate in the decode-stage control unit.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   start                   begin a run (sampled only in IDLE)
//   base_addr, length       run base address / word count, captured on start
//   in_valid / in_ready     field-bundle handshake (ready only in LOAD)
//   in_kind..in_imm         instruction fields
//   imem_we/addr/wdata      IMEM write port (one-cycle strobe)
//   busy, done, illegal     status; illegal is sticky until next start
//   word_cnt                words written in the current/last run
module instr_encoder_loader #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [11:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [11:0] imm;
  } fields_t;

  state_t            state, state_nxt;
  fields_t           f;
  logic [31:0]       enc;
  logic              enc_ill;
  logic              accept;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   len_q, cnt_q;
  logic [31:0]       wdata_q;
  logic              ill_q;

  assign f = '{kind: in_kind, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
               funct3: in_funct3, alt: in_alt, imm: in_imm};

  // Encoder: unused positions are constants of the format, never input bits.
  always_comb begin
    enc     = 32'h0000_0013;
    enc_ill = 1'b0;
    unique case (f.kind)
      3'd0: enc = {f.imm, f.rs1, 3'b011, f.rd, 7'b0000011};
      3'd1: enc = {f.imm[11:5], f.rs2, f.rs1, 3'b011, f.imm[4:0], 7'b0100011};
      3'd2: enc = {f.imm, f.rs1, f.funct3, f.rd, 7'b0010011};
      3'd3: enc = {1'b0, f.alt, 5'b00000, f.rs2, f.rs1, f.funct3, f.rd, 7'b0110011};
      // Branch/jump offsets are in halfwords, so imm maps straight onto
      // offset bits [12:1] in the scattered B/J layouts.
      3'd4: enc = {f.imm[11], f.imm[9:4], f.rs2, f.rs1, 3'b000,
                   f.imm[3:0], f.imm[10], 7'b1100011};
      3'd5: enc = {f.imm[11], f.imm[9:0], f.imm[10], {8{f.imm[11]}},
                   f.rd, 7'b1101111};
      default: begin
        enc     = 32'h0000_0013;
        enc_ill = 1'b1;
      end
    endcase
  end

  assign accept = (state == LOAD) && in_valid;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = (length == '0) ? DONE : LOAD;
      LOAD:  if (in_valid) state_nxt = WRITE;
      WRITE: state_nxt = (cnt_q + 1'b1 == len_q) ? DONE : LOAD;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      ill_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        addr_q <= base_addr;
        len_q  <= length;
        cnt_q  <= '0;
        ill_q  <= 1'b0;
      end
      if (accept) begin
        wdata_q <= enc;
        if (enc_ill) ill_q <= 1'b1;
      end
      if (state == WRITE) begin
        addr_q <= addr_q + 1'b1;  // wraps modulo 2^ADDR_W
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  // Outputs decode from state or come straight from registers.
  assign in_ready   = (state == LOAD);
  assign imem_we    = (state == WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign illegal    = ill_q;
  assign word_cnt   = cnt_q;

endmodule
